fp_norm_iter: RTL and testbench

//  Iterative post-add/sub normaliser: consumes the consumer side of the 8-bit leading-zero count.

---
 rtl/fp_norm_pkg.sv | 15 +
 rtl/lzc_8_bit.sv | 18 +
 rtl/fp_norm_iter.sv | 160 ++++++++++++++++
 tb/tb_fp_norm_iter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fp_norm_pkg.sv
// Shared types and constants for the iterative normaliser.
package fp_norm_pkg;

  // Width of the mantissa window inspected by the leading-zero counter each step
  localparam int LZC_WIN = 8;
  // Width of one step's shift amount (0..8)
  localparam int SHAMT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/lzc_8_bit.sv
// 8-bit leading-zero counter.
// z = number of leading zeros when the window is non-zero; v = 1 (and z = 0) when it is all zero.
module lzc_8_bit (
  input  logic [7:0] win,
  output logic [2:0] z,
  output logic       v
);

  // Scan from LSB upwards so the highest set bit wins the last assignment
  always_comb begin
    v = (win == 8'd0);
    z = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (win[i]) z = 3'(7 - i);
    end
  end

endmodule

// File: rtl/fp_norm_iter.sv
// Iterative post-add/sub normaliser: left-shifts the mantissa up to 8 bits per
// cycle until its MSB is set, decrementing the exponent and clamping at 0.
// Build option: FP_NORM_FTZ_EN flushes denormal results (clamped or denormal
// input) to zero and flags them as both zero and underflow.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | waiting for an operand; in_ready = 1
//  SHIFT | one window shift per cycle; stays while the window is all zero
//  DONE  | result held on out_*; out_valid = 1 until out_ready
module fp_norm_iter
  import fp_norm_pkg::*;
#(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [MANT_W-1:0] out_mant,
  output logic              out_zero,
  output logic              out_uflow
);

  state_t state_q, state_d;

  logic              sign_q;
  logic [EXP_W-1:0]  exp_q;
  logic [MANT_W-1:0] mant_q;
  logic              zero_q;
  logic              uflow_q;

  logic [LZC_WIN-1:0] win;
  logic [2:0]         lz;
  logic               win_zero;
  logic [SHAMT_W-1:0] amt;
  logic [EXP_W-1:0]   lim;
  logic               clamp;
  logic [SHAMT_W-1:0] sh;
  logic [MANT_W-1:0]  mant_sh;
  logic [EXP_W-1:0]   exp_nx;
  logic               accept;
  logic               in_direct;

  assign win = mant_q[MANT_W-1 -: LZC_WIN];

  lzc_8_bit u_lzc (
    .win (win),
    .z   (lz),
    .v   (win_zero)
  );

  // Per-step shift amount and clamp decision; lim < amt <= 8 whenever clamp is
  // set, so its low bits are a valid shift amount
  always_comb begin
    amt     = win_zero ? SHAMT_W'(LZC_WIN) : {1'b0, lz};
    lim     = exp_q - EXP_W'(1);
    clamp   = (EXP_W'(amt) > lim);
    sh      = clamp ? lim[SHAMT_W-1:0] : amt;
    mant_sh = mant_q << sh;
    exp_nx  = exp_q - EXP_W'(amt);
  end

  assign accept    = in_valid && in_ready;
  // Exact zero and already-denormal operands skip the shift loop
  assign in_direct = (in_mant == '0) || (in_exp == '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = in_direct ? DONE : SHIFT;
      SHIFT:   if (clamp || !win_zero) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Datapath: capture on accept, then one shift/decrement per SHIFT cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q  <= 1'b0;
      exp_q   <= '0;
      mant_q  <= '0;
      zero_q  <= 1'b0;
      uflow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            sign_q  <= in_sign;
            zero_q  <= 1'b0;
            uflow_q <= 1'b0;
            if (in_mant == '0) begin
              exp_q  <= '0;
              mant_q <= '0;
              zero_q <= 1'b1;
            end else if (in_exp == '0) begin
`ifdef FP_NORM_FTZ_EN
              exp_q   <= '0;
              mant_q  <= '0;
              zero_q  <= 1'b1;
              uflow_q <= 1'b1;
`else
              exp_q  <= in_exp;
              mant_q <= in_mant;
`endif
            end else begin
              exp_q  <= in_exp;
              mant_q <= in_mant;
            end
          end
        end
        SHIFT: begin
          if (clamp) begin
            exp_q   <= '0;
            uflow_q <= 1'b1;
`ifdef FP_NORM_FTZ_EN
            mant_q  <= '0;
            zero_q  <= 1'b1;
`else
            mant_q  <= mant_sh;
`endif
          end else begin
            exp_q  <= exp_nx;
            mant_q <= mant_sh;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_sign  = sign_q;
  assign out_exp   = exp_q;
  assign out_mant  = mant_q;
  assign out_zero  = zero_q;
  assign out_uflow = uflow_q;

endmodule

// File: tb/tb_fp_norm_iter.sv
// Self-checking bench for fp_norm_iter (MANT_W=24, EXP_W=8).
module tb_fp_norm_iter;

`ifdef FP_NORM_FTZ_EN
  localparam bit FTZ = 1'b1;
`else
  localparam bit FTZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = '0;
  logic [23:0] in_mant = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_sign;
  logic [7:0]  out_exp;
  logic [23:0] out_mant;
  logic        out_zero;
  logic        out_uflow;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0]  exp;
    logic [23:0] mant;
    logic [7:0]  r_exp;
    logic [23:0] r_mant;
    logic        r_zero;
    logic        r_uflow;
    int          lat;
  } vec_t;

  vec_t tbl[9];

  fp_norm_iter #(.MANT_W(24), .EXP_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_exp   (out_exp),
    .out_mant  (out_mant),
    .out_zero  (out_zero),
    .out_uflow (out_uflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: normalise by the full leading-zero count in one go, limited by
  // the exponent headroom; latency counts the 8-bit windows that must be examined.
  function automatic vec_t model(input logic [7:0] e, input logic [23:0] m);
    vec_t r;
    int lz, h;
    r.exp = e; r.mant = m; r.r_zero = 1'b0; r.r_uflow = 1'b0;
    if (m == 24'd0) begin
      r.r_exp = 8'd0; r.r_mant = 24'd0; r.r_zero = 1'b1; r.lat = 1;
    end else if (e == 8'd0) begin
      r.lat = 1; r.r_exp = 8'd0;
      r.r_mant  = FTZ ? 24'd0 : m;
      r.r_zero  = FTZ;
      r.r_uflow = FTZ;
    end else begin
      lz = 0;
      while (m[23 - lz] == 1'b0) lz++;
      h = int'(e) - 1;
      if (lz <= h) begin
        r.r_mant = m << lz;
        r.r_exp  = 8'(int'(e) - lz);
        r.lat    = 1 + (lz + 8) / 8;
      end else begin
        r.r_mant  = FTZ ? 24'd0 : (m << h);
        r.r_exp   = 8'd0;
        r.r_uflow = 1'b1;
        r.r_zero  = FTZ;
        r.lat     = 1 + h / 8 + 1;
      end
    end
    return r;
  endfunction

  task automatic run_op(input logic s, input vec_t ex, input int hold);
    int n;
    int lat;
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk("in_ready_before_accept", in_ready, 1);
    in_sign = s; in_exp = ex.exp; in_mant = ex.mant; in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_mant = 24'($urandom); in_exp = 8'($urandom);
    lat = 1;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("latency", lat, ex.lat);
    chk("out_mant", out_mant, ex.r_mant);
    chk("out_exp", out_exp, ex.r_exp);
    chk("out_zero", out_zero, ex.r_zero);
    chk("out_uflow", out_uflow, ex.r_uflow);
    chk("out_sign", out_sign, s);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out_mant", out_mant, ex.r_mant);
      chk("hold_out_exp", out_exp, ex.r_exp);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_release", in_ready, 1);
    chk("out_valid_after_release", out_valid, 0);
  endtask

  initial begin
    vec_t r;
    logic [7:0]  e;
    logic [23:0] m;

    //          exp    mant        r_exp  r_mant                     zero  uflow  lat
    tbl[0] = '{8'h7F, 24'h800000, 8'h7F, 24'h800000,               1'b0, 1'b0,  2};
    tbl[1] = '{8'h80, 24'h000100, 8'h71, 24'h800000,               1'b0, 1'b0,  3};
    tbl[2] = '{8'h90, 24'h000000, 8'h00, 24'h000000,               1'b1, 1'b0,  1};
    tbl[3] = '{8'h05, 24'h000001, 8'h00, FTZ ? 24'h0 : 24'h000010, FTZ,  1'b1,  2};
    tbl[4] = '{8'h10, 24'h7FFFFF, 8'h0F, 24'hFFFFFE,               1'b0, 1'b0,  2};
    tbl[5] = '{8'h20, 24'h00FFFF, 8'h18, 24'hFFFF00,               1'b0, 1'b0,  3};
    tbl[6] = '{8'h00, 24'h000003, 8'h00, FTZ ? 24'h0 : 24'h000003, FTZ,  FTZ,   1};
    tbl[7] = '{8'h01, 24'h400000, 8'h00, FTZ ? 24'h0 : 24'h400000, FTZ,  1'b1,  2};
    tbl[8] = '{8'h10, 24'h000001, 8'h00, FTZ ? 24'h0 : 24'h008000, FTZ,  1'b1,  3};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_outputs", {out_sign, out_exp, out_mant, out_zero, out_uflow}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_in_ready", in_ready, 1);

    for (int i = 0; i < 9; i++) run_op(i[0], tbl[i], 0);

    // Backpressure: result held for 5 cycles with out_ready low
    run_op(1'b1, tbl[1], 5);

    // Reset in SHIFT aborts the operation
    in_sign = 1'b1; in_exp = 8'h80; in_mant = 24'h000100; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("abort_in_shift", in_ready, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_outputs", {out_sign, out_exp, out_mant, out_zero, out_uflow}, 0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("abort_no_result", out_valid, 0);
    end

    // Randomised operands against the reference model
    for (int i = 0; i < 200; i++) begin
      e = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 20)) : 8'($urandom_range(0, 255));
      m = 24'($urandom() >> $urandom_range(8, 32));
      r = model(e, m);
      run_op(1'($urandom_range(0, 1)), r, (i % 7 == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
